// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory responder.
//   state_t          : responder FSM states (S_CLEAR sweep, S_RUN service)
//   DEF_WDWIDTH      : default word width
//   DEF_PHYS_AWIDTH  : default port address width (word indices)
//   DEF_MEM_AWIDTH   : default implemented depth exponent
//   NOP_WORD         : all-zero word; drives the outputs when nothing is valid
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam int DEF_WDWIDTH     = 32;
    localparam int DEF_PHYS_AWIDTH = 16;
    localparam int DEF_MEM_AWIDTH  = 12;

    // Zero decodes as a NOP on the core side.
    localparam logic [DEF_WDWIDTH-1:0] NOP_WORD = '0;

endpackage

// File: rtl/tdp_ram.sv
// -----------------------------------------------------------------------------
// tdp_ram
// 2**AWIDTH x WDWIDTH array with one read-only port (A) and one read/write
// port (B). Both read outputs are registered; a same-address write on port B
// returns the old word on both ports (read-first).
// Ports:
//   clk     : clock
//   a_addr  : port A read address
//   a_data  : port A registered read data
//   b_addr  : port B address
//   b_we    : port B write strobe
//   b_wdata : port B write data
//   b_data  : port B registered read data
// -----------------------------------------------------------------------------
module tdp_ram #(
    parameter int WDWIDTH = 32,
    parameter int AWIDTH  = 12
) (
    input  logic               clk,
    input  logic [AWIDTH-1:0]  a_addr,
    output logic [WDWIDTH-1:0] a_data,
    input  logic [AWIDTH-1:0]  b_addr,
    input  logic               b_we,
    input  logic [WDWIDTH-1:0] b_wdata,
    output logic [WDWIDTH-1:0] b_data
);

    logic [WDWIDTH-1:0] mem [2**AWIDTH];

    // NOTE: the array and read registers have no reset so this maps onto block
    // RAM; the responder's clear sweep is what gives the contents a known value.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments mean the reads sample the word before
        // this cycle's write lands, which is exactly the read-first behaviour.
        a_data <= mem[a_addr];
        b_data <= mem[b_addr];
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the core's instruction and data ports. Owns one
// word-addressed RAM, zero-clears it after reset, then serves one fetch and
// one load/store per cycle with 1-cycle registered read latency.
// Build option: define MEM_WR_FWD_EN for write-first collisions (a same-word
// store returns st_data on the colliding load/fetch); default is read-first.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset
//   inst_addr    : instruction fetch word address
//   inst         : fetched word (0 while clearing or out of range)
//   mem_addr     : data access word address
//   st_data      : store data
//   write_enable : store strobe
//   ld_data      : load data (0 while clearing or out of range)
//   ready        : clear sweep complete
//   addr_err     : sticky out-of-range flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int WDWIDTH     = DEF_WDWIDTH,
    parameter int PHYS_AWIDTH = DEF_PHYS_AWIDTH,
    parameter int MEM_AWIDTH  = DEF_MEM_AWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PHYS_AWIDTH-1:0] inst_addr,
    output logic [WDWIDTH-1:0]     inst,
    input  logic [PHYS_AWIDTH-1:0] mem_addr,
    input  logic [WDWIDTH-1:0]     st_data,
    input  logic                   write_enable,
    output logic [WDWIDTH-1:0]     ld_data,
    output logic                   ready,
    output logic                   addr_err
);

    localparam logic [WDWIDTH-1:0] ZERO_WORD = WDWIDTH'(NOP_WORD);

    state_t                  state;
    logic [MEM_AWIDTH-1:0]   cnt;

    logic                    inst_in_range;
    logic                    mem_in_range;
    logic [MEM_AWIDTH-1:0]   inst_idx;
    logic [MEM_AWIDTH-1:0]   mem_idx;

    logic [MEM_AWIDTH-1:0]   b_addr;
    logic                    b_we;
    logic [WDWIDTH-1:0]      b_wdata;
    logic [WDWIDTH-1:0]      ram_inst;
    logic [WDWIDTH-1:0]      ram_ld;

    logic                    fwd_inst;
    logic                    fwd_ld;

    // Registered per-access qualifiers, aligned with the RAM output registers.
    logic                    inst_vld;
    logic                    ld_vld;
    logic                    inst_fwd;
    logic                    ld_fwd;
    logic [WDWIDTH-1:0]      fwd_data;

    // Shifting out the implemented bits works even when MEM_AWIDTH == PHYS_AWIDTH.
    assign inst_in_range = (inst_addr >> MEM_AWIDTH) == '0;
    assign mem_in_range  = (mem_addr  >> MEM_AWIDTH) == '0;
    assign inst_idx      = inst_addr[MEM_AWIDTH-1:0];
    assign mem_idx       = mem_addr[MEM_AWIDTH-1:0];

    // Port B belongs to the sweep while clearing, to the data port afterwards.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and no latch is inferred.
        b_addr  = cnt;
        b_we    = 1'b1;
        b_wdata = ZERO_WORD;
        if (state == S_RUN) begin
            b_addr  = mem_idx;
            b_we    = write_enable && mem_in_range;
            b_wdata = st_data;
        end
    end

`ifdef MEM_WR_FWD_EN
    assign fwd_ld   = write_enable && mem_in_range;
    assign fwd_inst = write_enable && mem_in_range && inst_in_range && (inst_idx == mem_idx);
`else
    assign fwd_ld   = 1'b0;
    assign fwd_inst = 1'b0;
`endif

    tdp_ram #(
        .WDWIDTH (WDWIDTH),
        .AWIDTH  (MEM_AWIDTH)
    ) u_ram (
        .clk     (clk),
        .a_addr  (inst_idx),
        .a_data  (ram_inst),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_wdata (b_wdata),
        .b_data  (ram_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            ready    <= 1'b0;
            addr_err <= 1'b0;
            inst_vld <= 1'b0;
            ld_vld   <= 1'b0;
            inst_fwd <= 1'b0;
            ld_fwd   <= 1'b0;
            fwd_data <= ZERO_WORD;
        end else begin
            inst_vld <= 1'b0;
            ld_vld   <= 1'b0;
            inst_fwd <= 1'b0;
            ld_fwd   <= 1'b0;
            fwd_data <= st_data;
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    inst_vld <= inst_in_range;
                    ld_vld   <= mem_in_range;
                    inst_fwd <= fwd_inst;
                    ld_fwd   <= fwd_ld;
                    // Every cycle in S_RUN is a load on the data port, so an
                    // out-of-range mem_addr flags whether or not it stores.
                    if (!inst_in_range || !mem_in_range) begin
                        addr_err <= 1'b1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    assign inst    = inst_vld ? (inst_fwd ? fwd_data : ram_inst) : ZERO_WORD;
    assign ld_data = ld_vld   ? (ld_fwd   ? fwd_data : ram_ld)   : ZERO_WORD;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder at MEM_AWIDTH=4 (16 words). A small
// memory model produces expected fetch/load words, which are queued when an
// access is driven and popped when the registered outputs appear.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int WD    = 32;
    localparam int PA    = 16;
    localparam int MA    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PA-1:0] inst_addr;
    logic [WD-1:0] inst;
    logic [PA-1:0] mem_addr;
    logic [WD-1:0] st_data;
    logic          write_enable;
    logic [WD-1:0] ld_data;
    logic          ready;
    logic          addr_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [WD-1:0] model_mem [DEPTH];
    logic          model_err;
    logic [WD-1:0] exp_inst_q [$];
    logic [WD-1:0] exp_ld_q   [$];

    mem_responder #(
        .WDWIDTH     (WD),
        .PHYS_AWIDTH (PA),
        .MEM_AWIDTH  (MA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addr    (inst_addr),
        .inst         (inst),
        .mem_addr     (mem_addr),
        .st_data      (st_data),
        .write_enable (write_enable),
        .ld_data      (ld_data),
        .ready        (ready),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [PA-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // One serviced cycle: drive at negedge, queue expectations, compare after posedge.
    task automatic access(input logic [PA-1:0] ia, input logic [PA-1:0] ma,
                          input logic we, input logic [WD-1:0] sd);
        logic [WD-1:0] ei;
        logic [WD-1:0] el;
        @(negedge clk);
        inst_addr    = ia;
        mem_addr     = ma;
        write_enable = we;
        st_data      = sd;
        ei = in_range(ia) ? model_mem[ia[MA-1:0]] : '0;
        el = in_range(ma) ? model_mem[ma[MA-1:0]] : '0;
`ifdef MEM_WR_FWD_EN
        if (we && in_range(ma)) begin
            el = sd;
            if (in_range(ia) && ia == ma) ei = sd;
        end
`endif
        if (we && in_range(ma)) model_mem[ma[MA-1:0]] = sd;
        if (!in_range(ia) || !in_range(ma)) model_err = 1'b1;
        exp_inst_q.push_back(ei);
        exp_ld_q.push_back(el);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check($sformatf("inst@%h", ia), inst, exp_inst_q.pop_front());
        check($sformatf("ld_data@%h", ma), ld_data, exp_ld_q.pop_front());
        check("addr_err", 32'(addr_err), 32'(model_err));
    endtask

    // Hold rst for the given cycles, then follow the clear sweep until ready.
    task automatic reset_and_sweep(input int cycles, input bit pulse_store);
        int n;
        @(negedge clk);
        rst          = 1'b1;
        inst_addr    = '0;
        mem_addr     = '0;
        write_enable = 1'b0;
        st_data      = '0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_err = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            if (pulse_store && n == 3) begin
                write_enable = 1'b1;
                mem_addr     = 16'd2;
                st_data      = 32'hFFFF_FFFF;
            end
            @(posedge clk);
            #1;
            write_enable = 1'b0;
            mem_addr     = '0;
            n++;
            check("sweep_inst", inst, 32'd0);
            check("sweep_ld_data", ld_data, 32'd0);
        end
        check("sweep_len", 32'(n), 32'd16);
    endtask

    initial begin
        inst_addr    = '0;
        mem_addr     = '0;
        write_enable = 1'b0;
        st_data      = '0;
        model_err    = 1'b0;

        // Clear sweep, with a store attempted mid-sweep that must be dropped.
        reset_and_sweep(2, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            access(16'(i), 16'(DEPTH - 1 - i), 1'b0, '0);
        end

        // Store then load / fetch the same word.
        access(16'd0, 16'd5, 1'b1, 32'hDEAD_BEEF);
        access(16'd5, 16'd5, 1'b0, '0);

        // Store/load collision, then a confirming load.
        access(16'd0, 16'd3, 1'b1, 32'h1234_5678);
        access(16'd0, 16'd3, 1'b0, '0);

        // Store/fetch collision, then a confirming fetch.
        access(16'd9, 16'd9, 1'b1, 32'hCAFE_F00D);
        access(16'd9, 16'd0, 1'b0, '0);

        // Word 2 survived the dropped store during the sweep.
        access(16'd2, 16'd2, 1'b0, '0);

        // Out-of-range store aliasing word 3, then sticky error checks.
        access(16'd0, 16'h0013, 1'b1, 32'hAAAA_5555);
        access(16'd0, 16'd3, 1'b0, '0);
        access(16'd0, 16'h0020, 1'b0, '0);
        access(16'h0040, 16'd1, 1'b0, '0);
        access(16'd15, 16'd15, 1'b1, 32'h0000_000F);
        access(16'd15, 16'd15, 1'b0, '0);

        // Reset from S_RUN re-clears memory and the error flag.
        access(16'd0, 16'd7, 1'b1, 32'h0000_0077);
        access(16'd7, 16'd7, 1'b0, '0);
        reset_and_sweep(1, 1'b0);
        access(16'd7, 16'd7, 1'b0, '0);
        access(16'd5, 16'd3, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the single-cycle-issue CPU core's instruction and data ports. It owns one word-addressed RAM shared by an instruction read port and a data read/write port. It answers `inst_addr` with `inst` and `mem_addr`/`st_data`/`write_enable` with `ld_data`, after a zero-clearing sweep at reset. It sits between the core and the board-level memory map, replacing a bare BRAM.

## Interface
Parameters:
- `WDWIDTH`, 32, word width.
- `PHYS_AWIDTH`, 16, address width seen on both ports; addresses are word indices.
- `MEM_AWIDTH`, 12, implemented depth is 2**MEM_AWIDTH words. Must be ≤ PHYS_AWIDTH.

Ports:
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_addr`  in  PHYS_AWIDTH  instruction fetch address.
- `inst`  out  WDWIDTH  fetched instruction word, registered.
- `mem_addr`  in  PHYS_AWIDTH  data access address.
- `st_data`  in  WDWIDTH  store data.
- `write_enable`  in  1  store strobe; one word per cycle.
- `ld_data`  out  WDWIDTH  load data, registered.
- `ready`  out  1  high once the clear sweep is complete.
- `addr_err`  out  1  sticky flag for an out-of-range access seen while `ready`.

## Operation
- The FSM has two states:
  - S_CLEAR: a sweep counter writes 0 to word `cnt` each cycle, counting 0 → 2**MEM_AWIDTH−1. After the last write it moves to S_RUN and sets `ready`.
  - S_RUN: normal service. It is left only on `rst`.
- In S_CLEAR both ports ignore their inputs. `inst` and `ld_data` are driven to 0, which decodes as a NOP, and stores are dropped.
- In range means `addr[PHYS_AWIDTH-1:MEM_AWIDTH] == 0`.
- Instruction port (S_RUN): `inst` takes mem[inst_addr] if in range, otherwise 0.
- Data port (S_RUN):
  - `ld_data` takes mem[mem_addr] if in range, otherwise 0.
  - When `write_enable` is high and the address is in range, mem[mem_addr] takes `st_data`.
  - An out-of-range store is dropped.
- `addr_err` sets on any out-of-range `inst_addr`, any out-of-range `mem_addr` with `write_enable`, or any out-of-range `mem_addr` read. It clears only on `rst`.
- Same-cycle collisions are resolved read-first by default (see Configuration):
  - A store and a load to the same word return the old data on `ld_data`.
  - A store and an instruction fetch to the same word return the old data on `inst`.
- Reset in mid-sweep or in S_RUN has the same effect: state returns to S_CLEAR, the counter goes to 0, and `ready` goes to 0. Memory is re-cleared from word 0.

## Timing
- Reset values: `inst`=0, `ld_data`=0, `ready`=0, `addr_err`=0, state=S_CLEAR, counter=0.
- The first posedge with `rst`=0 clears word 0. The posedge with index 2**MEM_AWIDTH−1 clears the last word and sets `ready`.
- The first serviced access is at the next posedge.
- Read latency is 1 cycle: an address presented before posedge N is reflected on the output after posedge N, on both ports.
- A store issued at posedge N is visible to any read issued at posedge N+1 or later.
- No backpressure: the ports accept one access per cycle each, unconditionally, in S_RUN.

## Configuration
- `MEM_WR_FWD_EN` defined: collisions are write-first.
  - A same-word store and load in one cycle returns `st_data` on `ld_data`.
  - A same-word store and fetch in one cycle returns `st_data` on `inst`.
- `MEM_WR_FWD_EN` undefined: read-first, as in Operation.
- The clear sweep, error flag and latency are identical in both builds.

## Structure
- Package `mem_pkg` holds:
  - the state typedef (`S_CLEAR`, `S_RUN`);
  - the default width constants;
  - the zero/NOP word constant.
- Sub-module `tdp_ram`: a 2**MEM_AWIDTH × WDWIDTH array with one read-only port and one read/write port, read-first, registered outputs, so that it maps to BRAM.
- The FSM, range checks, forwarding mux and error flag live in `mem_responder`.

## Test plan
All scenarios use the bench build MEM_AWIDTH=4 (16 words).
- Clear sweep: assert `rst` for 2 cycles, then release. `ready` rises after exactly 16 posedges. `inst` and `ld_data` stay 0 throughout. Loads of words 0..15 then return 0.
- Store/load: store 0xDEADBEEF to word 5, then load word 5 the next cycle. `ld_data` is 0xDEADBEEF one cycle later. A fetch of `inst_addr`=5 also returns 0xDEADBEEF.
- Collision: store 0x12345678 to word 3 while loading word 3 in the same cycle.
  - Default build: `ld_data` is the old value 0.
  - With `MEM_WR_FWD_EN`: `ld_data` is 0x12345678.
  - In both builds the following load returns 0x12345678.
- Out of range: store 0xAAAA5555 to address 0x0013. Nothing is written (word 3 is unchanged) and `addr_err` goes to 1 and stays 1. A load from 0x0020 returns 0.
- Store during clear: pulse `write_enable` with address 2 and data 0xFFFFFFFF while `ready`=0. Once `ready`=1, word 2 reads 0.
- Reset mid-run: store 0x77 to word 7, assert `rst` for 1 cycle, then release. `ready` and `addr_err` go to 0, `ready` returns 16 cycles later, and word 7 reads 0.
